dcfifo_rd_stream: RTL
=====================

// Module: dcfifo_rd_stream
// PURPOSE
//  Read-side drainer for a show-ahead dcfifo (LPM_SHOWAHEAD="ON"), in the read clock domain.
//  Pops words with rdreq and frames them into bursts on a valid/ready stream with last flag.
//  A burst starts on a fill threshold or an idle timeout. It consumes the producer traffic
//  written on the wrclk side.
// PARAMETERS
//  DWIDTH     12   data width; equals the FIFO LPM_WIDTH
//  AWIDTH     8    rdusedw width; equals the FIFO LPM_WIDTHU
//  BURST_LEN  16   nominal beats per burst; 2..2**AWIDTH
//  TIMEOUT    64   cycles of non-empty idle before a short burst is forced; >=2
// PORTS
//  rdclk         in   1       read clock; the only clock
//  aclr_n        in   1       asynchronous active-low reset
//  fifo_q        in   DWIDTH  FIFO show-ahead data; valid while fifo_rdempty=0
//  fifo_rdempty  in   1       FIFO empty flag
//  fifo_rdusedw  in   AWIDTH  FIFO fill level; 0 with rdempty=0 means full (2**AWIDTH)
//  fifo_rdreq    out  1       pop/acknowledge the current fifo_q
//  m_data        out  DWIDTH  stream data
//  m_valid       out  1       stream valid
//  m_ready       in   1       stream ready
//  m_last        out  1       final beat of the burst
//  busy          out  1       state != IDLE
//  burst_cnt     out  16      completed bursts; wraps
//  seq_err       out  1       one-cycle pulse on a sequence break (see CONFIGURATION)
//  seq_err_cnt   out  16      saturating count of sequence errors
// BEHAVIOUR
//  - Reset (aclr_n=0, asynchronous):
//    - state=IDLE; all outputs 0; buffer emptied; counters 0.
//    - FIFO contents are untouched, so words not yet popped remain in the FIFO.
//    - Reset in mid-burst discards buffered beats with no m_last.
//  - fifo_rdreq = (state==BURST) & ~fifo_rdempty & (pop_cnt<blen) & (buf_cnt<2).
//    - Combinational from registers plus fifo_rdempty.
//    - Never asserted while fifo_rdempty=1, so the FIFO never underflows.
//  - Buffer: 2-entry skid FIFO feeding registered m_data/m_valid/m_last.
//    - A popped word reaches m_valid on the next rdclk edge (1-cycle latency).
//    - With m_ready held high the stream sustains 1 beat/cycle.
//  - Handshake:
//    - A beat transfers on m_valid & m_ready.
//    - m_data and m_last are held stable while m_valid=1 & m_ready=0.
//    - m_valid never drops without a transfer.
//  - Full decode: lvl = (fifo_rdusedw==0 & ~fifo_rdempty) ? 2**AWIDTH : fifo_rdusedw, width AWIDTH+1.
//  - FSM IDLE:
//    - wait_cnt increments while ~fifo_rdempty and clears when empty.
//    - Threshold start: if lvl>=BURST_LEN, then blen=BURST_LEN and go to BURST.
//    - Timeout start: else if wait_cnt==TIMEOUT-1, then blen=lvl and go to BURST.
//    - Threshold wins if both hold in the same cycle.
//    - pop_cnt=0 on entry to BURST.
//  - FSM BURST:
//    - pop_cnt increments per rdreq.
//    - If fifo_rdempty rises (usedw lag), popping stalls with no error.
//    - m_last is tagged on the word where pop_cnt==blen-1.
//    - Go to DRAIN when pop_cnt==blen.
//  - FSM DRAIN:
//    - Stay until the m_last beat transfers.
//    - Then burst_cnt+=1 (mod 2**16) and go to IDLE.
//    - A new burst may be decided in the cycle after return to IDLE.
//  - wait_cnt saturates at TIMEOUT-1 and is cleared on BURST entry.
// CONFIGURATION
//  DCFIFO_RD_SEQ_CHECK_EN defined:
//    - Each transferred beat is checked; expected = prev+1 mod 2**DWIDTH.
//    - A beat equal to 1 is always accepted (producer restart).
//    - The first beat after reset is accepted and loads prev.
//    - On a mismatch: seq_err pulses for 1 cycle, seq_err_cnt+=1 (saturating at 16'hFFFF),
//      and prev is reloaded from that beat.
//  Not defined: checker logic is absent; seq_err=0 and seq_err_cnt=0 constantly; ports remain.
// TESTING
//  T1 threshold burst: write 1..20 into an empty FIFO, m_ready=1
//     -> one burst of 16 beats (1..16), m_last on 16, burst_cnt=1.
//     Then after TIMEOUT cycles -> a 4-beat burst 17..20 with m_last on 20, burst_cnt=2.
//  T2 backpressure: 16 words, m_ready toggling 1,0,0,1,...
//     -> no beat lost or duplicated; data held stable while stalled; fifo_rdreq never with rdempty=1.
//  T3 full decode: fill the FIFO to 256 (rdusedw=0, rdempty=0)
//     -> threshold start; 16 bursts of 16 beats; data 1..256 in order.
//  T4 reset mid-burst: aclr_n=0 after 5 beats of a 16-beat burst
//     -> all outputs 0 at once; after release, remaining FIFO words are drained in order.
//  T5 (SEQ_CHECK_EN) inject 1,2,3,7,8,1,2
//     -> seq_err pulses exactly once (on 7); seq_err_cnt=1; restart at 1 not flagged.
//  T6 timeout edge: one word written, m_ready=1
//     -> m_valid exactly TIMEOUT+1 cycles after rdempty falls, with m_last=1 and blen=1.

Source files
------------

// File: rtl/dcfifo_rd_stream.sv
// Show-ahead dcfifo read-side drainer framing words into bursts on a valid/ready stream.
// Optional sequence checker: define DCFIFO_RD_SEQ_CHECK_EN.
module dcfifo_rd_stream #(
  parameter int DWIDTH    = 12,
  parameter int AWIDTH    = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              rdclk,
  input  logic              aclr_n,
  input  logic [DWIDTH-1:0] fifo_q,
  input  logic              fifo_rdempty,
  input  logic [AWIDTH-1:0] fifo_rdusedw,
  output logic              fifo_rdreq,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       burst_cnt,
  output logic              seq_err,
  output logic [15:0]       seq_err_cnt
);
  localparam int CW = AWIDTH + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WMAX = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] BLEN_C = CW'(BURST_LEN);
  localparam logic [CW-1:0] FULL = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   wait_cnt;
  logic [CW-1:0]   pop_cnt, blen, blen_nxt, lvl;
  logic            start, xfer, pop_last;
  logic [DWIDTH:0] sb [2];
  logic            sb_rd, sb_wr;
  logic [1:0]      buf_cnt;
  logic            out_free, load_sb, load_in, push_sb;

  // rdusedw wraps to 0 when the FIFO is completely full
  assign lvl = (fifo_rdusedw == '0 && !fifo_rdempty) ? FULL
             : {1'b0, fifo_rdusedw};

  assign fifo_rdreq = (state == BURST) & ~fifo_rdempty
                    & (pop_cnt < blen) & (buf_cnt < 2'd2);
  assign pop_last = (pop_cnt == blen - 1'b1);
  assign xfer = m_valid & m_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    blen_nxt = blen;
    start = 1'b0;
    unique case (state)
      IDLE: begin
        if (lvl >= BLEN_C) begin
          start = 1'b1;
          blen_nxt = BLEN_C;
          state_nxt = BURST;
        end else if (wait_cnt == WMAX && !fifo_rdempty) begin
          start = 1'b1;
          blen_nxt = lvl;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (pop_cnt == blen || (fifo_rdreq && pop_last))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (xfer && m_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rdclk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
      wait_cnt <= '0;
      pop_cnt <= '0;
      blen <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      blen <= blen_nxt;
      if (start)
        pop_cnt <= '0;
      else if (fifo_rdreq)
        pop_cnt <= pop_cnt + 1'b1;
      if (state != IDLE || start || fifo_rdempty)
        wait_cnt <= '0;
      else if (wait_cnt != WMAX)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == DRAIN && xfer && m_last)
        burst_cnt <= burst_cnt + 16'd1;
    end
  end

  // Popped words bypass the skid entries when the output stage is free
  assign out_free = ~m_valid | m_ready;
  assign load_sb = out_free & (buf_cnt != 2'd0);
  assign load_in = out_free & (buf_cnt == 2'd0) & fifo_rdreq;
  assign push_sb = fifo_rdreq & ~load_in;

  always_ff @(posedge rdclk or negedge aclr_n) begin
    if (!aclr_n) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
      sb[0] <= '0;
      sb[1] <= '0;
      sb_rd <= 1'b0;
      sb_wr <= 1'b0;
      buf_cnt <= '0;
    end else begin
      if (load_sb) begin
        {m_last, m_data} <= sb[sb_rd];
        m_valid <= 1'b1;
        sb_rd <= ~sb_rd;
      end else if (load_in) begin
        {m_last, m_data} <= {pop_last, fifo_q};
        m_valid <= 1'b1;
      end else if (out_free) begin
        m_valid <= 1'b0;
      end
      if (push_sb) begin
        sb[sb_wr] <= {pop_last, fifo_q};
        sb_wr <= ~sb_wr;
      end
      unique case ({push_sb, load_sb})
        2'b10: buf_cnt <= buf_cnt + 2'd1;
        2'b01: buf_cnt <= buf_cnt - 2'd1;
        default: ;
      endcase
    end
  end

`ifdef DCFIFO_RD_SEQ_CHECK_EN
  logic              prev_vld;
  logic [DWIDTH-1:0] prev;
  logic              mis;

  assign mis = xfer & prev_vld & (m_data != DWIDTH'(1))
             & (m_data != prev + DWIDTH'(1));

  always_ff @(posedge rdclk or negedge aclr_n) begin
    if (!aclr_n) begin
      prev_vld <= 1'b0;
      prev <= '0;
      seq_err <= 1'b0;
      seq_err_cnt <= '0;
    end else begin
      seq_err <= mis;
      if (xfer) begin
        prev <= m_data;
        prev_vld <= 1'b1;
      end
      if (mis && seq_err_cnt != 16'hFFFF)
        seq_err_cnt <= seq_err_cnt + 16'd1;
    end
  end
`else
  assign seq_err = 1'b0;
  assign seq_err_cnt = 16'd0;
`endif

endmodule
